// File: rtl/imem_loader_if.sv
// Byte-stream, fetch and status signals between the program loader and the core side.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        core_reset;
    logic        busy;
    logic        load_error;

    modport master (
        output rx_valid, rx_data, PC,
        input  instruction, core_reset, busy, load_error
    );

    modport slave (
        input  rx_valid, rx_data, PC,
        output instruction, core_reset, busy, load_error
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (A5, N lo/hi, 4N data
// bytes, XOR checksum) into a word RAM, holds the core in reset until a frame
// checks out, and serves instruction fetches combinationally from PC.
module imem_loader #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_count;
    logic [ADDR_W:0] r_wr_ptr;
    logic [1:0]      r_byte_idx;
    logic [7:0]      r_csum;
    logic [23:0]     r_buf;
    logic [31:0]     r_mem [DEPTH_WORDS];
    logic            r_core_reset;
    logic            r_busy;
    logic            r_load_error;

    logic            w_core_reset_nxt;
    logic            w_busy_nxt;
    logic            w_load_error_nxt;
    logic [15:0]     w_count_full;
    logic            w_len_bad;
    logic [16:0]     w_ptr_next;
    logic            w_last_word;
    logic            w_data_byte;
    logic            w_we;
    logic            w_unused_pc;

    // The count limit is checked at 17 bits so N == DEPTH_WORDS is representable
    assign w_count_full = {bus.rx_data, r_count[7:0]};
    assign w_len_bad    = (w_count_full == '0) ||
                          ({1'b0, w_count_full} > 17'(DEPTH_WORDS));
    assign w_ptr_next   = 17'(r_wr_ptr) + 17'd1;
    assign w_last_word  = (w_ptr_next == {1'b0, r_count});
    assign w_data_byte  = !reset && bus.rx_valid && (r_state == S_DATA);
    assign w_we         = w_data_byte && (r_byte_idx == 2'd3);

    // Next-state decode and registered-output targets
    always_comb begin
        w_state_nxt = r_state;
        if (bus.rx_valid) begin
            case (r_state)
                S_IDLE:   if (bus.rx_data == 8'hA5) w_state_nxt = S_LEN_LO;
                S_LEN_LO: w_state_nxt = S_LEN_HI;
                S_LEN_HI: w_state_nxt = w_len_bad ? S_ERROR : S_DATA;
                S_DATA:   if (r_byte_idx == 2'd3 && w_last_word) w_state_nxt = S_CSUM;
                S_CSUM:   w_state_nxt = (bus.rx_data == r_csum) ? S_RUN : S_ERROR;
                S_RUN,
                S_ERROR:  if (bus.rx_data == 8'hA5) w_state_nxt = S_LEN_LO;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
        w_core_reset_nxt = (w_state_nxt != S_RUN);
        w_busy_nxt       = (w_state_nxt == S_LEN_LO) || (w_state_nxt == S_LEN_HI) ||
                           (w_state_nxt == S_DATA)   || (w_state_nxt == S_CSUM);
        w_load_error_nxt = (w_state_nxt == S_ERROR);
    end

    // State register; status outputs follow the state entered on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_reset <= w_core_reset_nxt;
            r_busy       <= w_busy_nxt;
            r_load_error <= w_load_error_nxt;
        end
    end

    // Frame datapath: length latch, write pointer, byte lane and running checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
        end else if (bus.rx_valid) begin
            case (r_state)
                S_LEN_LO: r_count[7:0] <= bus.rx_data;
                S_LEN_HI: begin
                    r_count[15:8] <= bus.rx_data;
                    r_wr_ptr      <= '0;
                    r_byte_idx    <= '0;
                    r_csum        <= '0;
                end
                S_DATA: begin
                    r_csum     <= r_csum ^ bus.rx_data;
                    r_byte_idx <= r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Word assembly and RAM write; the RAM is never cleared
    always_ff @(posedge clk) begin
        if (w_data_byte && r_byte_idx != 2'd3) r_buf <= {bus.rx_data, r_buf[23:8]};
        if (w_we) r_mem[r_wr_ptr[ADDR_W-1:0]] <= {bus.rx_data, r_buf};
    end

    assign bus.instruction = r_mem[bus.PC[ADDR_W+1:2]];
    assign bus.core_reset  = r_core_reset;
    assign bus.busy        = r_busy;
    assign bus.load_error  = r_load_error;

    // Byte-offset and above-RAM PC bits take no part in the fetch
    assign w_unused_pc = ^{bus.PC[31:ADDR_W+2], bus.PC[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, length bounds, gaps,
// reload from RUN, and reset in the middle of a frame.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;
    logic [31:0] q[$];

    imem_loader_if bus();

    imem_loader #(.DEPTH_WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // exp = {core_reset, busy, load_error}
    task automatic st(input string tag, input logic [2:0] exp);
        chk(tag, {29'b0, bus.core_reset, bus.busy, bus.load_error}, {29'b0, exp});
    endtask

    task automatic rd(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        bus.PC = pc;
        #1;
        chk(tag, bus.instruction, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the words in q as one frame; gap idle cycles after each data byte,
    // checksum XORed with flip (non-zero flip corrupts it)
    task automatic send_frame(input int gap, input logic [7:0] flip);
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        cs = '0;
        n  = 16'(q.size());
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        foreach (q[i]) begin
            w = q[i];
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ w[8*k +: 8];
                send_byte(w[8*k +: 8]);
                if (gap > 0) idle(gap);
            end
        end
        send_byte(cs ^ flip);
    endtask

    logic [7:0] good [12];

    initial begin
        // Checksum of 13 00 00 00 93 00 10 00 is 0x13^0x93^0x10 = 0x90
        good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.PC       = '0;
        idle(2);
        reset = 1'b0;
        st("reset_state", 3'b100);

        // Noise before the magic byte is ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        st("noise_idle", 3'b100);

        // Good frame, back-to-back
        for (int i = 0; i < 12; i++) begin
            send_byte(good[i]);
            if (i == 0)  st("busy_after_a5", 3'b110);
            if (i == 10) st("busy_before_csum", 3'b110);
        end
        st("good_run", 3'b000);
        rd("good_pc0", 32'h0, 32'h00000013);
        rd("good_pc4", 32'h4, 32'h00100093);
        rd("good_pc6", 32'h6, 32'h00100093);

        // Bad checksum, then recovery with the good frame
        for (int i = 0; i < 11; i++) send_byte(good[i]);
        send_byte(8'h84);
        st("bad_csum_err", 3'b101);
        for (int i = 0; i < 12; i++) send_byte(good[i]);
        st("recover_run", 3'b000);

        // Zero count goes straight to ERROR and writes nothing
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        st("count0_err", 3'b101);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        rd("count0_nowrite", 32'h0, 32'h00000013);

        // Count 0x0401 exceeds the RAM
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        st("count401_err", 3'b101);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        rd("count401_nowrite", 32'h4, 32'h00100093);

        // Full-depth frame
        q.delete();
        for (int i = 0; i < 1024; i++) q.push_back(32'hC0DE0000 | 32'(i));
        send_frame(0, 8'h00);
        st("full_run", 3'b000);
        rd("full_wrap", 32'h1000, 32'hC0DE0000);
        rd("full_last", 32'hFFC, 32'hC0DE03FF);
        rd("full_mid", 32'h804, 32'hC0DE0201);

        // Gapped delivery matches back-to-back result
        q = '{32'h00000013, 32'h00100093};
        send_frame(3, 8'h00);
        st("gap_run", 3'b000);
        rd("gap_w0", 32'h0, 32'h00000013);
        rd("gap_w1", 32'h4, 32'h00100093);
        rd("gap_w2_kept", 32'h8, 32'hC0DE0002);

        // Reload from RUN: core_reset rises on the A5 edge
        send_byte(8'hA5);
        st("reload_a5", 3'b110);
        // EF^BE^AD^DE = 0x22
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h22);
        st("reload_run", 3'b000);
        rd("reload_w0", 32'h0, 32'hDEADBEEF);
        rd("reload_w1_kept", 32'h4, 32'h00100093);

        // Reset after two data bytes discards the frame
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h11);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        st("midreset_idle", 3'b100);

        // Reset wins over a simultaneous magic byte
        reset        = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        idle(1);
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        st("reset_priority", 3'b100);

        q = '{32'h11111111, 32'h22222222};
        send_frame(0, 8'h00);
        st("after_reset_run", 3'b000);
        rd("after_reset_w0", 32'h0, 32'h11111111);
        rd("after_reset_w1", 32'h4, 32'h22222222);
        rd("after_reset_w2", 32'h8, 32'hC0DE0002);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
